mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_wdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Contents: FSM state enum, owner enum, bus command codes, watchdog limit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [3:0] WDOG_MAX = 4'd15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/memory bus bundle between requesters, arbiter and memory
// Signals: fetch request (if_*), data request (dm_*), memory side (mem_*), completions,
//          read data, stalls and bus_err.
// Modports: master = requesters/memory side, slave = arbiter side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic [1:0]  dm_cmd;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        if_done;
  logic        dm_done;
  logic [31:0] if_rdata;
  logic [31:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  modport master (
    output if_req, if_addr, dm_req, dm_cmd, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  mem_cmd, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata,
           stall_if, stall_mem, bus_err
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_cmd, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output mem_cmd, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata,
           stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// rtl/mem_port_arbiter_wdog.sv - 4-bit watchdog (module arb_watchdog) for a stuck memory command
// Ports: clk, rst (async, active-high); clr zeroes the count; en counts one ack-less
//        busy cycle; expired flags the ack-less cycle that completes WDOG_MAX of them.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (en && (cnt_q != WDOG_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the ack-less cycle whose increment would reach WDOG_MAX, so the
  // arbiter leaves BUSY after exactly WDOG_MAX cycles without an ack.
  assign expired = en && (cnt_q == (WDOG_MAX - 4'd1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch (IF) and data (DM) requests onto one memory port
// Ports: clk, rst (async, active-high), bus (mem_port_arbiter_if.slave).
// Config macro: ARB_RR_EN - when defined, simultaneous requests alternate using last_served;
//               otherwise DM always wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  arb_owner_e  grant;
  logic        bus_err_q, bus_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        busy;
  logic        wd_clr;
  logic        wd_en;
  logic        wd_expired;

`ifdef ARB_RR_EN
  arb_owner_e  last_q, last_d;
`endif

  assign busy   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_DM);
  // Every BUSY entry comes from IDLE, so clearing there gives a zero count on entry.
  assign wd_clr = (state_q == ST_IDLE);
  assign wd_en  = busy && !bus.mem_ack;

  arb_watchdog u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Winner among the current requests; only meaningful when at least one is high.
  always_comb begin
    grant = OWN_DM;
    if (bus.if_req && !bus.dm_req) begin
      grant = OWN_IF;
    end
`ifdef ARB_RR_EN
    else if (bus.if_req && bus.dm_req) begin
      grant = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    bus_err_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          owner_d = grant;
          state_d = (grant == OWN_DM) ? ST_BUSY_DM : ST_BUSY_IF;
        end
      end
      ST_BUSY_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          state_d    = ST_RESP;
        end else if (wd_expired) begin
          if_rdata_d = 32'd0;
          bus_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_BUSY_DM: begin
        if (bus.mem_ack) begin
          dm_rdata_d = bus.mem_rdata;
          state_d    = ST_RESP;
        end else if (wd_expired) begin
          dm_rdata_d = 32'd0;
          bus_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      bus_err_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      bus_err_q  <= bus_err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (state_q == ST_RESP) begin
      last_d = owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    bus.mem_cmd   = BUS_NONE;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    if (state_q == ST_BUSY_IF) begin
      bus.mem_cmd  = BUS_LOAD;
      bus.mem_addr = bus.if_addr;
    end else if (state_q == ST_BUSY_DM) begin
      bus.mem_cmd   = bus.dm_cmd;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end
  end

  assign bus.if_done   = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign bus.dm_done   = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  // bus_err_q is only ever set on the transition into RESP, so it spans that cycle alone.
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req && !bus.if_done;
  assign bus.stall_mem = bus.dm_req && !bus.dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level reference state.
  bit          m_last_dm = 1'b0;
  logic [31:0] m_if_rd   = 32'd0;
  logic [31:0] m_dm_rd   = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: a lone request wins; both -> DM, or the one not served last with RR.
  function automatic bit pick_dm(input bit i, input bit d, input bit last_dm);
    if (i && d) return RR ? !last_dm : 1'b1;
    return d;
  endfunction

  // Entered during an IDLE cycle with requests already driven; leaves in the IDLE
  // cycle that follows RESP. ack_dly = index of the BUSY cycle carrying mem_ack
  // (>= 15 means no ack, so the watchdog must fire).
  task automatic serve(input int ack_dly, input logic [31:0] rd, input bit drop, output bit got_dm);
    bit          w_dm;
    bit          tmo;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    w_dm   = pick_dm(bus.if_req, bus.dm_req, m_last_dm);
    e_cmd  = w_dm ? bus.dm_cmd : BUS_LOAD;
    e_addr = w_dm ? bus.dm_addr : bus.if_addr;
    got_dm = 1'b0;
    tmo    = 1'b1;
    #1;
    check("idle_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    check("idle_done", 32'({bus.if_done, bus.dm_done}), 32'd0);
    @(posedge clk); #1;
    for (int b = 0; b < 15; b++) begin
      if (b == ack_dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
      end
      #1;
      if (b == 0) got_dm = (bus.mem_addr === bus.dm_addr) && bus.dm_req;
      check("busy_cmd", 32'(bus.mem_cmd), 32'(e_cmd));
      check("busy_addr", bus.mem_addr, e_addr);
      if (w_dm) check("busy_wdata", bus.mem_wdata, bus.dm_wdata);
      check("busy_done", 32'({bus.if_done, bus.dm_done}), 32'd0);
      check("busy_stall", 32'({bus.stall_if, bus.stall_mem}), 32'({bus.if_req, bus.dm_req}));
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (b == ack_dly) begin
        tmo = 1'b0;
        break;
      end
    end
    #1;
    if (w_dm) m_dm_rd = tmo ? 32'd0 : rd;
    else      m_if_rd = tmo ? 32'd0 : rd;
    check("resp_done", 32'({bus.if_done, bus.dm_done}), w_dm ? 32'd1 : 32'd2);
    check("resp_bus_err", 32'(bus.bus_err), 32'(tmo));
    check("resp_if_rdata", bus.if_rdata, m_if_rd);
    check("resp_dm_rdata", bus.dm_rdata, m_dm_rd);
    check("resp_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    check("resp_addr", bus.mem_addr, 32'd0);
    check("resp_wdata", bus.mem_wdata, 32'd0);
    check("resp_stall", 32'({bus.stall_if, bus.stall_mem}),
          32'({bus.if_req & w_dm, bus.dm_req & !w_dm}));
    m_last_dm   = w_dm;
    // An ack during RESP must have no effect.
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    if (drop) begin
      if (w_dm) bus.dm_req = 1'b0;
      else      bus.if_req = 1'b0;
    end
    #1;
    check("post_done", 32'({bus.if_done, bus.dm_done}), 32'd0);
    check("post_bus_err", 32'(bus.bus_err), 32'd0);
    check("post_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit          got;
    bit          seen;
    bit          exp_dm;
    logic [31:0] tmp;
    int          dly;

    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.dm_req    = 1'b0;
    bus.dm_cmd    = BUS_NONE;
    bus.dm_addr   = 32'd0;
    bus.dm_wdata  = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_done", 32'({bus.if_done, bus.dm_done}), 32'd0);
    check("rst_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
    check("rst_stall_err", 32'({bus.stall_if, bus.stall_mem, bus.bus_err}), 32'd0);
    rst = 1'b0;

    // Lone fetch at 0x100, ack in the third BUSY cycle.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    serve(2, 32'hCAFE_0001, 1'b1, got);
    check("fetch_owner", 32'(got), 32'd0);

    // Simultaneous fetch and store: DM first, IF right after.
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0300;
    bus.dm_req   = 1'b1;
    bus.dm_cmd   = BUS_STORE;
    bus.dm_addr  = 32'h0000_0200;
    bus.dm_wdata = 32'hDEAD_BEEF;
    serve(1, 32'h1111_2222, 1'b1, got);
    check("both_first_owner", 32'(got), 32'd1);
    serve(0, 32'h3333_4444, 1'b1, got);
    check("both_second_owner", 32'(got), 32'd0);

    // Both held for four transactions.
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0400;
    bus.dm_req   = 1'b1;
    bus.dm_cmd   = BUS_LOAD;
    bus.dm_addr  = 32'h0000_0500;
    bus.dm_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      exp_dm = RR ? ((k % 2) == 0) : 1'b1;
      serve(k, 32'hA000_0000 + 32'(k), 1'b0, got);
      check($sformatf("held_order_%0d", k), 32'(got), 32'(exp_dm));
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;

    // No ack at all: watchdog timeout on a DM load.
    bus.dm_req  = 1'b1;
    bus.dm_cmd  = BUS_LOAD;
    bus.dm_addr = 32'h0000_0600;
    serve(99, 32'h5555_5555, 1'b1, got);
    check("timeout_owner", 32'(got), 32'd1);

    // Spurious ack in IDLE.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    #1;
    check("spur_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    check("spur_done_err", 32'({bus.if_done, bus.dm_done, bus.bus_err}), 32'd0);
    check("spur_if_rdata", bus.if_rdata, m_if_rd);
    check("spur_dm_rdata", bus.dm_rdata, m_dm_rd);
    @(posedge clk); #1;
    check("spur_cmd_later", 32'(bus.mem_cmd), 32'(BUS_NONE));

    // Reset while a store is in flight.
    bus.dm_req   = 1'b1;
    bus.dm_cmd   = BUS_STORE;
    bus.dm_addr  = 32'h0000_0700;
    bus.dm_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    check("pre_rst_cmd", 32'(bus.mem_cmd), 32'(BUS_STORE));
    rst = 1'b1;
    #1;
    check("in_rst_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    check("in_rst_rdata", bus.dm_rdata | bus.if_rdata, 32'd0);
    bus.dm_req = 1'b0;
    m_last_dm  = 1'b0;
    m_if_rd    = 32'd0;
    m_dm_rd    = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_cmd", 32'(bus.mem_cmd), 32'(BUS_NONE));
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      seen = seen | bus.dm_done | (bus.mem_cmd != BUS_NONE);
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    // Randomised traffic against the model.
    for (int t = 0; t < 40; t++) begin
      if (!bus.if_req && ($urandom_range(0, 1) == 1)) begin
        tmp         = $urandom;
        bus.if_req  = 1'b1;
        bus.if_addr = {1'b0, tmp[30:0]};
      end
      if (!bus.dm_req && (!bus.if_req || ($urandom_range(0, 1) == 1))) begin
        tmp          = $urandom;
        bus.dm_req   = 1'b1;
        bus.dm_cmd   = ($urandom_range(0, 1) == 1) ? BUS_STORE : BUS_LOAD;
        bus.dm_addr  = {1'b1, tmp[30:0]};
        bus.dm_wdata = $urandom;
      end
      dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      serve(dly, $urandom, 1'($urandom_range(0, 1)), got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
